// File: rtl/spmv_row_mac.sv
// spmv_row_mac: pairs gathered x elements with matrix values,
// multiplies them and accumulates one signed 64-bit y per row.
// Ports: clk/rstn; Ctrl_sig_Val element width; Xi stream into a
// skid FIFO; Val stream; Row_len stream (nnz per row); Y result
// stream; Rows_done counter; Busy status.
module spmv_row_mac #(
    parameter int XI_FIFO_DEPTH = 4,
    parameter int ROWCNT_W      = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          Ctrl_sig_Val,
    input  logic                Xi_valid,
    input  logic [63:0]         Xi_data,
    output logic                Xi_ready,
    input  logic                Val_valid,
    input  logic [63:0]         Val_data,
    output logic                Val_ready,
    input  logic                Row_len_valid,
    input  logic [ROWCNT_W-1:0] Row_len,
    output logic                Row_len_ready,
    output logic                Y_valid,
    output logic [63:0]         Y_data,
    input  logic                Y_ready,
    output logic [ROWCNT_W-1:0] Rows_done,
    output logic                Busy
);

    localparam int PW = $clog2(XI_FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DRAIN,
        EMIT
    } state_t;

    state_t              state;
    logic [63:0]         mem [XI_FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [ROWCNT_W-1:0] remaining;
    logic [1:0]          width_r;
    logic [63:0]         acc;
    logic [63:0]         prod;
    logic                pipe_valid;
    logic                row_len_ready_r;
    logic                y_valid_r;
    logic [63:0]         y_data_r;
    logic [ROWCNT_W-1:0] rows_done_r;

    logic                fifo_empty;
    logic                push;
    logic                pair_fire;
    logic [63:0]         mult;

    // Right-aligned operand, sign-extended from the row's width.
    function automatic logic [63:0] sext(
        input logic [63:0] v,
        input logic [1:0]  w
    );
        case (w)
            2'd0:    return {{48{v[15]}}, v[15:0]};
            2'd1:    return {{32{v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

    assign fifo_empty = (count == '0);
    assign Xi_ready   = (count < CW'(XI_FIFO_DEPTH));
    assign push       = Xi_valid & Xi_ready;
    assign pair_fire  = (state == ACC) & ~fifo_empty & Val_valid;
    assign Val_ready  = pair_fire;

    // Low 64 bits of the extended product equal the exact 16x16 or
    // 32x32 signed result, and the truncated product for 64b.
    assign mult = sext(mem[rd_ptr], width_r) * sext(Val_data, width_r);

    assign Row_len_ready = row_len_ready_r;
    assign Y_valid       = y_valid_r;
    assign Y_data        = y_data_r;
    assign Rows_done     = rows_done_r;
    assign Busy          = (state != IDLE) | pipe_valid;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= Xi_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)      wr_ptr <= wr_ptr + 1'b1;
            if (pair_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pair_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            remaining       <= '0;
            width_r         <= 2'd0;
            acc             <= '0;
            prod            <= '0;
            pipe_valid      <= 1'b0;
            row_len_ready_r <= 1'b0;
            y_valid_r       <= 1'b0;
            y_data_r        <= '0;
            rows_done_r     <= '0;
        end else begin
            if (pipe_valid) acc <= acc + prod;
            pipe_valid <= pair_fire;
            if (pair_fire) begin
                prod      <= mult;
                remaining <= remaining - 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (Row_len_valid && row_len_ready_r) begin
                        remaining       <= Row_len;
                        width_r         <= Ctrl_sig_Val;
                        acc             <= '0;
                        row_len_ready_r <= 1'b0;
                        if (Row_len == '0) begin
                            state     <= EMIT;
                            y_valid_r <= 1'b1;
                            y_data_r  <= '0;
                        end else begin
                            state <= ACC;
                        end
                    end else begin
                        row_len_ready_r <= 1'b1;
                    end
                end
                ACC: begin
                    if (pair_fire && remaining == ROWCNT_W'(1))
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Last product is still in the pipe this cycle.
                    state     <= EMIT;
                    y_valid_r <= 1'b1;
                    y_data_r  <= pipe_valid ? acc + prod : acc;
                end
                EMIT: begin
                    if (Y_ready) begin
                        y_valid_r       <= 1'b0;
                        rows_done_r     <= rows_done_r + 1'b1;
                        row_len_ready_r <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spmv_row_mac.sv
// tb_spmv_row_mac: directed scoreboard bench for spmv_row_mac.
// Queue-fed stream drivers; a monitor checks every Y beat.
module tb_spmv_row_mac;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  Ctrl_sig_Val = 2'd3;
    logic        Xi_valid = 1'b0;
    logic [63:0] Xi_data = '0;
    logic        Xi_ready;
    logic        Val_valid = 1'b0;
    logic [63:0] Val_data = '0;
    logic        Val_ready;
    logic        Row_len_valid = 1'b0;
    logic [31:0] Row_len = '0;
    logic        Row_len_ready;
    logic        Y_valid;
    logic [63:0] Y_data;
    logic        Y_ready = 1'b1;
    logic [31:0] Rows_done;
    logic        Busy;

    spmv_row_mac #(.XI_FIFO_DEPTH(4), .ROWCNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .Ctrl_sig_Val(Ctrl_sig_Val),
        .Xi_valid(Xi_valid), .Xi_data(Xi_data), .Xi_ready(Xi_ready),
        .Val_valid(Val_valid), .Val_data(Val_data),
        .Val_ready(Val_ready), .Row_len_valid(Row_len_valid),
        .Row_len(Row_len), .Row_len_ready(Row_len_ready),
        .Y_valid(Y_valid), .Y_data(Y_data), .Y_ready(Y_ready),
        .Rows_done(Rows_done), .Busy(Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] len;
        logic [1:0]  w;
    } row_t;

    row_t        rq[$];
    logic [63:0] xq[$];
    logic [63:0] vq[$];
    logic [63:0] expq[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_evt = 0;
    bit          cur_zero = 0;
    bit          v_en = 1;
    logic [31:0] rows_exp = '0;
    bit          pend = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h", n, a, e);
        end
    endtask

    task automatic add_row(input logic [31:0] len,
                           input logic [1:0] w,
                           input logic [63:0] e);
        row_t r;
        r.len = len;
        r.w   = w;
        rq.push_back(r);
        expq.push_back(e);
    endtask

    task automatic wait_done(input string n);
        int k;
        k = 0;
        while ((rq.size() != 0 || expq.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s timeout rows %0d exp %0d", n,
                     rq.size(), expq.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Xi stream driver
    initial begin : xdrv
        bit          f;
        logic [63:0] t;
        forever begin
            @(negedge clk);
            f = rstn && Xi_valid && Xi_ready;
            @(posedge clk);
            #1;
            if (f && xq.size() > 0) t = xq.pop_front();
            Xi_valid = (xq.size() > 0);
            Xi_data  = (xq.size() > 0) ? xq[0] : '0;
        end
    end

    // Val stream driver
    initial begin : vdrv
        bit          f;
        logic [63:0] t;
        forever begin
            @(negedge clk);
            f = rstn && Val_valid && Val_ready;
            if (f) last_evt = cyc;
            @(posedge clk);
            #1;
            if (f && vq.size() > 0) t = vq.pop_front();
            Val_valid = v_en && (vq.size() > 0);
            Val_data  = (vq.size() > 0) ? vq[0] : '0;
        end
    end

    // Row length driver; width goes to 3 once a row is taken so
    // mid-row width changes are exercised.
    initial begin : rdrv
        bit   f;
        row_t t;
        forever begin
            @(negedge clk);
            f = rstn && Row_len_valid && Row_len_ready;
            if (f) begin
                cur_zero = (Row_len == 0);
                last_evt = cyc;
            end
            @(posedge clk);
            #1;
            if (f && rq.size() > 0) t = rq.pop_front();
            Row_len_valid = (rq.size() > 0);
            Row_len       = (rq.size() > 0) ? rq[0].len : '0;
            Ctrl_sig_Val  = (rq.size() > 0) ? rq[0].w : 2'd3;
        end
    end

    // Y monitor / scoreboard
    initial begin : mon
        bit          prev_yv;
        logic [63:0] t;
        prev_yv = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_yv = 0;
            end else begin
                if (pend) begin
                    chk("rows_done", 64'(Rows_done), 64'(rows_exp));
                    pend = 0;
                end
                if (Y_valid && !prev_yv)
                    chk("y_latency", 64'(cyc - last_evt),
                        cur_zero ? 64'd1 : 64'd2);
                if (Y_valid) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL y_unexpected got %h", Y_data);
                    end else begin
                        chk("y_data", Y_data, expq[0]);
                        if (!Y_ready) begin
                            chk("rl_ready_emit",
                                64'(Row_len_ready), 64'd0);
                        end else begin
                            t = expq.pop_front();
                            rows_exp = rows_exp + 1;
                            pend = 1;
                        end
                    end
                end
                prev_yv = Y_valid;
            end
        end
    end

    initial begin : main
        int          k;
        logic [31:0] snap;
        #3;
        chk("rst_y_valid", 64'(Y_valid), 64'd0);
        chk("rst_y_data", Y_data, 64'd0);
        chk("rst_rows", 64'(Rows_done), 64'd0);
        chk("rst_val_ready", 64'(Val_ready), 64'd0);
        chk("rst_rl_ready", 64'(Row_len_ready), 64'd0);
        chk("rst_xi_ready", 64'(Xi_ready), 64'd1);
        chk("rst_busy", 64'(Busy), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 32b row: 10 - 18 - 4 = -12
        xq.push_back(64'd2);
        xq.push_back(-64'sd3);
        xq.push_back(64'd4);
        vq.push_back(64'd5);
        vq.push_back(64'd6);
        vq.push_back(-64'sd1);
        add_row(32'd3, 2'd1, 64'hFFFF_FFFF_FFFF_FFF4);
        wait_done("t_32b");

        // empty row; the buffered x/val wait for the next row
        xq.push_back(64'h0000_0000_0000_FFFC);
        vq.push_back(64'd3);
        add_row(32'd0, 2'd1, 64'd0);
        wait_done("t_len0");
        chk("len0_no_val_pop", 64'(vq.size()), 64'd1);
        add_row(32'd1, 2'd0, 64'hFFFF_FFFF_FFFF_FFF4);
        wait_done("t_len0_next");

        // 16b upper bits ignored; then 64b truncation
        xq.push_back(64'h0000_0000_ABCD_FFFF);
        vq.push_back(64'h0000_0000_0000_7FFF);
        add_row(32'd1, 2'd0, 64'hFFFF_FFFF_FFFF_8001);
        xq.push_back(64'h0000_0001_0000_0000);
        xq.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        vq.push_back(64'h0000_0001_0000_0000);
        vq.push_back(64'd5);
        add_row(32'd2, 2'd2, 64'hFFFF_FFFF_FFFF_FFFB);
        wait_done("t_16_64");

        // 32b: (-2) * (-2^31) = 2^32
        xq.push_back(64'hDEAD_BEEF_FFFF_FFFE);
        vq.push_back(64'h0000_0000_8000_0000);
        add_row(32'd1, 2'd1, 64'h0000_0001_0000_0000);
        wait_done("t_32_ext");

        // FIFO fill with values stalled, then drain
        v_en = 0;
        for (int i = 1; i <= 6; i++) begin
            xq.push_back(64'(i));
            vq.push_back(64'(10 * i));
        end
        add_row(32'd6, 2'd1, 64'd910);
        repeat (8) @(negedge clk);
        chk("fifo_full_ready", 64'(Xi_ready), 64'd0);
        chk("fifo_accepted", 64'(xq.size()), 64'd2);
        chk("busy_acc", 64'(Busy), 64'd1);
        v_en = 1;
        @(negedge clk);
        chk("first_pop", 64'(Val_ready), 64'd1);
        chk("full_at_pop", 64'(Xi_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_pop", 64'(Xi_ready), 64'd1);
        wait_done("t_fifo");

        // backpressure on Y
        Y_ready = 1'b0;
        xq.push_back(64'd9);
        vq.push_back(64'd9);
        add_row(32'd1, 2'd1, 64'd81);
        k = 0;
        while (!Y_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("bp_y_seen", 64'(Y_valid), 64'd1);
        xq.push_back(64'd3);
        vq.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        add_row(32'd1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFA);
        snap = rows_exp;
        repeat (5) begin
            @(negedge clk);
            chk("bp_rows_hold", 64'(Rows_done), 64'(snap));
        end
        @(posedge clk);
        #1;
        Y_ready = 1'b1;
        wait_done("t_bp");

        // reset in the middle of a row
        for (int i = 1; i <= 4; i++) xq.push_back(64'(i));
        vq.push_back(64'd1);
        vq.push_back(64'd1);
        begin
            row_t r;
            r.len = 32'd4;
            r.w   = 2'd1;
            rq.push_back(r);
        end
        k = 0;
        while (vq.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("mid_busy", 64'(Busy), 64'd1);
        rstn = 1'b0;
        #1;
        xq.delete();
        vq.delete();
        rq.delete();
        expq.delete();
        rows_exp = '0;
        pend = 0;
        chk("mr_y_valid", 64'(Y_valid), 64'd0);
        chk("mr_rows", 64'(Rows_done), 64'd0);
        chk("mr_xi_ready", 64'(Xi_ready), 64'd1);
        chk("mr_val_ready", 64'(Val_ready), 64'd0);
        chk("mr_rl_ready", 64'(Row_len_ready), 64'd0);
        chk("mr_busy", 64'(Busy), 64'd0);
        chk("mr_y_data", Y_data, 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        xq.push_back(64'd7);
        vq.push_back(64'd3);
        add_row(32'd1, 2'd1, 64'd21);
        wait_done("t_after_rst");
        chk("final_rows", 64'(Rows_done), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spmv_row_mac.md
Name: spmv_row_mac

Overview:
- Downstream consumer of the Xi gather stage: pairs each gathered x element with its matrix value and multiplies them.
- Accumulates products per row and emits one y result per row on a valid/ready stream.
- Contains an Xi skid FIFO that absorbs the back-to-back Xi beats produced by outstanding AXI reads, so the gather stage is never stalled by the multiplier.
- Rows are delimited by a per-row nonzero-count stream.

Parameters:
- XI_FIFO_DEPTH, 4, entries in Xi skid FIFO; power of two, min 2.
- ROWCNT_W, 32, width of the row-length field and the rows_done counter.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- Ctrl_sig_Val  in  2  element width: 0=16b, 1=32b, 2=64b, 3 treated as 64b
- Xi_valid  in  1  gathered x element valid
- Xi_data  in  64  x element, right-aligned; upper bits ignored for narrow widths
- Xi_ready  out  1  FIFO can accept
- Val_valid  in  1  matrix value valid
- Val_data  in  64  matrix value, right-aligned
- Val_ready  out  1  value consumed
- Row_len_valid  in  1  row nnz count valid
- Row_len  in  ROWCNT_W  nonzeros in this row
- Row_len_ready  out  1  row count accepted
- Y_valid  out  1  row result valid
- Y_data  out  64  row result (signed, modulo 2^64)
- Y_ready  in  1  downstream accepts result
- Rows_done  out  ROWCNT_W  rows emitted since reset
- Busy  out  1  FSM not in IDLE or multiply pipe non-empty

Behaviour:
- Reset (async assert, sync release): FIFO empty; FSM=IDLE; accumulator=0; pipe valid=0; Y_valid=0; Y_data=0; Rows_done=0; Val_ready=0; Row_len_ready=0; Xi_ready=1 (FIFO empty).
- Reset mid-row discards the FIFO contents, the partial sum and any pending Y.
- Xi FIFO:
  - Xi_ready = (count < XI_FIFO_DEPTH); push on Xi_valid&Xi_ready.
  - Simultaneous push and pop at full is not allowed, since Xi_ready is already 0 at full.
  - Simultaneous push and pop otherwise leaves count unchanged.
  - Pointers wrap modulo depth.
- FSM states: IDLE, ACC, DRAIN, EMIT.
- IDLE:
  - Row_len_ready=1; on the handshake, latch Row_len into remaining, latch Ctrl_sig_Val into width_r, clear accumulator.
  - Row_len==0 -> EMIT with Y_data=0 next cycle.
  - Otherwise -> ACC.
- ACC:
  - pair_fire = FIFO non-empty & Val_valid. Val_ready=pair_fire; FIFO pop=pair_fire.
  - On fire: operands are sign-extended from width_r bits to 64, product registered into the pipe (1-cycle multiply stage), remaining decremented.
  - On the fire with remaining==1 -> DRAIN.
- Pipe stage: when pipe valid, acc <= acc + product (64-bit, wraps, no saturation). A pipe add and a new fire may occur in the same cycle (full throughput, 1 pair/cycle).
- DRAIN: wait one cycle for the last product to add; -> EMIT with Y_data=acc+last product, Y_valid=1.
- Latency: Y_valid rises 2 cycles after the last pair handshake.
- Width rules:
  - 16b: 16x16 -> 32b signed product, sign-extended to 64.
  - 32b: 32x32 -> 64b full product.
  - 64b: low 64 bits of the product.
- EMIT:
  - Y_valid held, Y_data stable until Y_ready.
  - On handshake: Y_valid=0, Rows_done+1 (wraps at 2^ROWCNT_W), -> IDLE.
  - Row_len_ready stays 0 while in EMIT; the next row starts at the earliest the cycle after the Y handshake.
- Xi beats arriving during IDLE/EMIT/DRAIN are buffered in the FIFO, not dropped; Val_ready=0 outside ACC.
- Ctrl_sig_Val changes mid-row are ignored until the next row start.

Test Plan:
- Width 32b, Row_len=3, x={2,-3,4}, val={5,6,-1}, all valid continuously, Y_ready=1 -> Y_data=0xFFFFFFFFFFFFFFF4 (-12), Y_valid exactly 2 cycles after the third pair; Rows_done=1.
- Row_len=0 with Y_ready=1 -> Y_valid the cycle after the row handshake with Y_data=0; no Val/Xi consumed; Rows_done increments.
- Width 16b, Xi_data=0xABCD_FFFF (low half -1), Val_data=0x0000_7FFF, Row_len=1 -> Y_data=0xFFFFFFFFFFFF8001.
- Val_valid=0 while 6 Xi beats are offered back-to-back -> 4 accepted, Xi_ready=0 after the 4th; then Val enabled -> FIFO drains 1/cycle, Xi_ready reasserts the cycle after the first pop; all sums correct.
- Y_ready held 0 for 5 cycles in EMIT -> Y_data stable, Row_len_ready=0, next row not started; release -> Rows_done+1, next row proceeds.
- Assert rstn low mid-ACC (2 of 4 pairs consumed) -> all outputs return to reset values immediately; after release a fresh row of length 1 (x=7, val=3) yields Y_data=21.
